// File: rtl/uart_program_loader.sv
// UART program loader: receives 8N1 bytes, packs them little-endian into 32-bit
// instruction words and streams them into program memory until an end marker or a full image.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [31:0]       prog_wdata,
    output logic              load_done,
    output logic              frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BITS_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [ADDR_W-1:0] TOP_ADDR   = {{(ADDR_W - 2){1'b1}}, 2'b00};
    localparam logic [31:0]       END_MARKER = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CNT_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [1:0]           byte_idx;
    logic [23:0]          word_buf;
    logic [ADDR_W-1:0]    waddr;
    logic [7:0]           rx_byte;
    logic [31:0]          full_word;

    assign rx_byte   = 8'(shift_reg);
    // Bytes 0..2 sit in word_buf; the fourth byte is still in the shift register.
    assign full_word = {rx_byte, word_buf};

    // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // NOTE: non-blocking assignments everywhere so each branch sees pre-edge register values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            waddr      <= '0;
            prog_we    <= 1'b0;
            prog_addr  <= '0;
            prog_wdata <= '0;
            load_done  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            prog_we   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == BITS_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                        end else if (!load_done) begin
                            if (byte_idx != 2'd3) begin
                                word_buf <= {rx_byte, word_buf[23:8]};
                                byte_idx <= byte_idx + 2'd1;
                            end else begin
                                byte_idx <= '0;
                                if (full_word == END_MARKER) begin
                                    load_done <= 1'b1;
                                end else begin
                                    prog_we    <= 1'b1;
                                    prog_addr  <= waddr;
                                    prog_wdata <= full_word;
                                    // The last slot ends the image; the address is never wrapped.
                                    if (waddr == TOP_ADDR) begin
                                        load_done <= 1'b1;
                                    end else begin
                                        waddr <= waddr + ADDR_W'(4);
                                    end
                                end
                            end
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: random words over a fast serial line,
// checked every cycle against a word-level model of the loader.
module tb_uart_program_loader;

    localparam int CPB = 16;
    localparam int TOP = 252;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_wdata;
    logic        load_done;
    logic        frame_err;

    always #5 clk = ~clk;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .load_done  (load_done),
        .frame_err  (frame_err)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    int compared   = 0;
    int mismatched = 0;

    wr_t        exp_q[$];
    logic [7:0] m_bytes[4];
    int         m_idx  = 0;
    int         m_addr = 0;
    bit         m_done = 1'b0;
    int         m_fe   = 0;

    bit          prev_we   = 1'b0;
    bit          prev_fe   = 1'b0;
    logic [7:0]  last_addr = '0;
    logic [31:0] last_data = '0;
    int          fe_seen   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: advance to the falling edge and compare every output against the model.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (!rst) begin
            prev_we   = 1'b0;
            prev_fe   = 1'b0;
            last_addr = '0;
            last_data = '0;
        end else begin
            if (prog_we === 1'b1) begin
                check("we_single_cycle", 32'(prev_we), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_we", 32'(prog_we), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("we_addr", 32'(prog_addr), 32'(e.addr));
                    check("we_data", prog_wdata, e.data);
                    check("done_with_we", 32'(load_done), 32'(e.addr == 8'(TOP)));
                    last_addr = e.addr;
                    last_data = e.data;
                end
            end else begin
                check("hold_addr", 32'(prog_addr), 32'(last_addr));
                check("hold_data", prog_wdata, last_data);
            end
            if (frame_err === 1'b1) begin
                fe_seen++;
                check("fe_single_cycle", 32'(prev_fe), 32'd0);
            end
            prev_we = prog_we;
            prev_fe = frame_err;
        end
    endtask

    task automatic model_reset();
        m_idx  = 0;
        m_addr = 0;
        m_done = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok);
        logic [31:0] w;
        if (!ok) begin
            m_fe++;
        end else if (!m_done) begin
            m_bytes[m_idx] = b;
            m_idx++;
            if (m_idx == 4) begin
                m_idx = 0;
                w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                if (w == 32'hFFFF_FFFF) begin
                    m_done = 1'b1;
                end else begin
                    exp_q.push_back('{addr: 8'(m_addr), data: w});
                    if (m_addr == TOP) m_done = 1'b1;
                    else m_addr += 4;
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok, input int gap);
        model_byte(b, ok);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = ok;
        repeat (CPB) tick();
        rx = 1'b1;
        check("write_by_frame_end", 32'(exp_q.size()), 32'd0);
        check("load_done", 32'(load_done), 32'(m_done));
        check("frame_err_count", 32'(fe_seen), 32'(m_fe));
        repeat (ok ? gap : gap + 2 * CPB) tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1, $urandom_range(0, 3));
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        do w = $urandom; while (w == 32'hFFFF_FFFF);
        return w;
    endfunction

    task automatic reset_outputs_zero(input string tag);
        check({tag, "_we"},    32'(prog_we),   32'd0);
        check({tag, "_addr"},  32'(prog_addr), 32'd0);
        check({tag, "_wdata"}, prog_wdata,     32'd0);
        check({tag, "_done"},  32'(load_done), 32'd0);
        check({tag, "_ferr"},  32'(frame_err), 32'd0);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        rx  = 1'b1;
        model_reset();
        tick();
        reset_outputs_zero("rst");
        repeat (3) tick();
        rst = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        logic [31:0] w;
        int          glen;

        repeat (3) tick();
        reset_outputs_zero("por");
        rst = 1'b1;
        repeat (4) tick();

        // Two hand-computed words pin the model.
        send_word(32'h0000_0013);
        check("pin_addr_w0", 32'(prog_addr), 32'h00);
        check("pin_data_w0", prog_wdata, 32'h0000_0013);
        send_word(32'h0000_0063);
        check("pin_addr_w1", 32'(prog_addr), 32'h04);
        check("pin_data_w1", prog_wdata, 32'h0000_0063);

        // Short low glitches between bytes of a word must not count as bytes.
        for (int g = 0; g < 3; g++) begin
            w = rand_word();
            send_byte(w[7:0], 1'b1, 2);
            send_byte(w[15:8], 1'b1, 2);
            glen = $urandom_range(1, CPB / 2 - 3);
            rx = 1'b0;
            repeat (glen) tick();
            rx = 1'b1;
            repeat (2 * CPB) tick();
            check("glitch_no_ferr", 32'(fe_seen), 32'(m_fe));
            send_byte(w[23:16], 1'b1, 0);
            send_byte(w[31:24], 1'b1, 0);
            check("pin_glitch_data", prog_wdata, w);
        end

        for (int k = 0; k < 3; k++) send_word(rand_word());

        // A framing error discards its byte without advancing the byte index.
        do_reset();
        send_byte(8'hAA, 1'b0, 0);
        w = rand_word();
        send_word(w);
        check("pin_ferr_addr", 32'(prog_addr), 32'h00);
        check("pin_ferr_data", prog_wdata, w);

        // Reset in the middle of a byte discards the partial word.
        w = rand_word();
        send_byte(w[7:0], 1'b1, 1);
        send_byte(w[15:8], 1'b1, 1);
        rx = 1'b0;
        repeat (3 * CPB) tick();
        do_reset();
        send_word(32'h4433_2211);
        check("pin_rst_addr", 32'(prog_addr), 32'h00);
        check("pin_rst_data", prog_wdata, 32'h4433_2211);

        // End marker after two words stops loading.
        send_word(rand_word());
        send_word(32'hFFFF_FFFF);
        check("pin_marker_done", 32'(load_done), 32'd1);
        check("pin_marker_addr", 32'(prog_addr), 32'h04);
        send_word(rand_word());
        send_byte(8'h5A, 1'b0, 0);
        check("pin_after_done_addr", 32'(prog_addr), 32'h04);

        // A full image ends at the top address; one more word is ignored.
        do_reset();
        for (int k = 0; k < 64; k++) send_word(rand_word());
        check("pin_full_addr", 32'(prog_addr), 32'hFC);
        check("pin_full_done", 32'(load_done), 32'd1);
        send_word(rand_word());
        check("pin_extra_addr", 32'(prog_addr), 32'hFC);
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
